// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: shared state encoding and requester count for the arbiter
package rr_arbiter4_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int NREQ = 4;
endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between requesters and the arbiter
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic [1:0]      gnt_id;
  logic            timeout;
  modport master (output req, input gnt, gnt_valid, gnt_id, timeout);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, timeout);
endinterface

// File: rtl/rr_arbiter4_decoder24.sv
// decoder24: enable-gated 2-to-4 one-hot decoder
module decoder24 (
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic [3:0] y_o
);
  assign y_o = en_i ? 4'b0001 << sel_i : 4'b0000;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with bounded grant tenure
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter4_if.slave arb
);
  logic [0:0]       state_q, state_d;
  logic [1:0]       id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  // first requester after the previous owner; walking backwards lets the nearest one win
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction
  // grant on any request in IDLE; release on owner drop, else force release at tenure limit
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = '0;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (|arb.req) begin
        state_d = BUSY;
        id_d    = rr_pick(arb.req, id_q);
      end
    end else if (!arb.req[id_q]) begin
      state_d = IDLE;
    end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
      state_d = IDLE;
      to_d    = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  // state registers; id resets to 3 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 2'd3;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
  decoder24 u_dec (
    .en_i  (state_q == BUSY),
    .sel_i (id_q),
    .y_o   (arb.gnt)
  );
  assign arb.gnt_valid = state_q == BUSY;
  assign arb.gnt_id    = id_q;
  assign arb.timeout   = to_q;
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-way round-robin arbiter that shares one downstream resource between four requesters. It is the grant/sequencing controller in front of the 2-to-4 decoded select path: it picks one requester, holds the grant while that requester keeps its request up, and forces release after a bounded tenure. The one-hot grant comes from the team's existing 2-to-4 decoder, driven by the registered winner index.

## Interface
Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may stay asserted (legal range 1..255).
- CNT_W, 8: width of the tenure counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports (clock and reset first):
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  4  request vector, bit i = requester i; level-sensitive.
- gnt  output  4  one-hot grant; all-zero when no grant.
- gnt_valid  output  1  high whenever any gnt bit is high.
- gnt_id  output  2  index of current owner; holds last owner while idle.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- States: IDLE (no grant) and BUSY (one owner granted).
- Reset (rst high at an edge): state IDLE, gnt=4'b0000, gnt_valid=0, gnt_id=2'd3, timeout=0, tenure counter 0. Because gnt_id resets to 3, requester 0 has top priority first.
- IDLE: if req is non-zero, select the first set bit searching gnt_id+1, gnt_id+2, gnt_id+3, gnt_id (mod 4). Load gnt_id with it, go BUSY, clear counter. If req is zero, stay IDLE.
- BUSY: gnt = decode(gnt_id), gnt_valid=1, counter increments every BUSY cycle.
  - req[gnt_id]=0: go IDLE (normal release), timeout=0.
  - req[gnt_id]=1 and counter = MAX_HOLD-1: go IDLE, timeout=1 for that one cycle (forced release).
  - Otherwise stay BUSY.
  - If release and timeout conditions coincide in a cycle, normal release wins: timeout stays 0.
- Requests from non-owners during BUSY are ignored; they are evaluated in the IDLE cycle that follows.
- A forcibly released owner gets no penalty beyond rotation. If it is the only requester, it is re-granted after the IDLE bubble.
- Two grants never overlap: every owner change passes through at least one IDLE cycle with gnt=0.
- rst asserted in BUSY: grant removed at that edge, and all outputs take their reset values.

## Timing
- All outputs are registered; none depends combinationally on req.
- Grant latency: req sampled in IDLE at edge N, so gnt is visible after edge N+1.
- Release latency: owner drops req before edge M, so gnt=0 after edge M.
- Maximum tenure: gnt high for exactly MAX_HOLD cycles when the owner never drops req. timeout is high in the cycle after the last grant cycle, coincident with gnt=0.
- Minimum gap between consecutive grants: 1 cycle.
- Back-to-back full contention (req=4'b1111): grant sequence 0,1,2,3,0,... Each owner holds for MAX_HOLD cycles, separated by 1-cycle gaps.

## Structure
- Shared package holds the state encoding (IDLE=1'b0, BUSY=1'b1) and the requester count constant NREQ=4.
- Sub-module: the existing 2-to-4 decoder (decoder24), instantiated once to turn gnt_id into gnt, gated by BUSY.
- Priority search sits in a single combinational function inside the block; no further sub-modules.

## Test plan
- Reset then single request: rst for 2 cycles, req=4'b0100, hold 3 cycles, then req=0 -> gnt=4'b0100 for 3 cycles starting 1 cycle after req, gnt_id=2, then gnt=0, timeout never set.
- Full contention, MAX_HOLD=8: req=4'b1111 held 40 cycles -> owners 0,1,2,3 in order, each gnt run exactly 8 cycles, timeout pulse after each run, 1-cycle zero gap between runs.
- Rotation fairness: owner 1 releases while req=4'b1011 -> next grant is 3 (not 0), then 0, then 1.
- Coincident release/timeout: owner drops req in its 8th cycle -> gnt=0 next cycle, timeout stays 0.
- Sole hog: req=4'b0001 held 20 cycles -> gnt 8 on, 1 off, 8 on; timeout pulses twice.
- Reset mid-grant: rst pulsed during cycle 3 of a grant to requester 2 -> next cycle gnt=0, gnt_id=3, timeout=0. With req=4'b0101 still high, the first post-reset grant goes to 0.
